// File: rtl/logo_pkg.sv
// rtl/logo_pkg.sv - shared state encoding and framing constants for the logo frame controller
package logo_pkg;

    typedef enum logic [2:0] {
        ST_HUNT0     = 3'd0,
        ST_HUNT1     = 3'd1,
        ST_PAYLOAD   = 3'd2,
        ST_WAIT_SWAP = 3'd3,
        ST_RESYNC    = 3'd4,
        ST_CHECK     = 3'd5
    } logo_state_e;

    localparam logic [7:0] HDR0_DEF      = 8'hA5;
    localparam logic [7:0] HDR1_DEF      = 8'h5A;
    localparam int         LOGO_W        = 320;
    localparam int         LOGO_H        = 240;
    localparam int         NBYTES        = 2 * LOGO_W * LOGO_H;
    localparam int         SWAP_WAIT_CYC = 4;

endpackage

// File: rtl/logo_idle_timer.sv
// rtl/logo_idle_timer.sv - idle counter cleared on activity, pulses tc on the LIMIT-th idle cycle
module logo_idle_timer #(
    parameter int LIMIT = 1000000
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tc) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/logo_frame_ctrl.sv
// rtl/logo_frame_ctrl.sv - header hunt, payload forwarding and swap gating for the logo loader
// Optional trailer XOR check enabled by defining LOGO_FRAME_CHK_EN.
module logo_frame_ctrl
    import logo_pkg::*;
#(
    parameter int         WIDTH       = LOGO_W,
    parameter int         HEIGHT      = LOGO_H,
    parameter logic [7:0] HDR0        = HDR0_DEF,
    parameter logic [7:0] HDR1        = HDR1_DEF,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter int         ERR_W       = 8
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_vld,
    output logic [7:0]       ld_byte,
    output logic             ld_vld,
    output logic             ld_rst,
    input  logic             ld_swap_req,
    output logic             swap_req,
    output logic [15:0]      frame_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       state_o,
    output logic             busy
);

    localparam int              FRAME_BYTES = 2 * WIDTH * HEIGHT;
    localparam int              BCW         = $clog2(FRAME_BYTES);
    localparam logic [BCW-1:0]  LAST_IDX    = BCW'(FRAME_BYTES - 1);
    localparam int              WCW         = $clog2(SWAP_WAIT_CYC);
    localparam logic [WCW-1:0]  WAIT_LAST   = WCW'(SWAP_WAIT_CYC - 1);

    logo_state_e      state_q, state_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]       ld_byte_q, ld_byte_d;
    logic             ld_vld_q, ld_vld_d;
    logic             ld_rst_q, ld_rst_d;
    logic             swap_req_q, swap_req_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_evt;
    logic             timer_act;
    logic             idle_tc;

`ifdef LOGO_FRAME_CHK_EN
    logic [7:0] xor_q, xor_d;
    logic       tr_vld_q, tr_vld_d;
    logic [7:0] tr_byte_q, tr_byte_d;
`endif

    logo_idle_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk_sys  (clk_sys),
        .rst_sys_n(rst_sys_n),
        .clr      (!timer_act || rx_vld),
        .en       (timer_act && !rx_vld),
        .tc       (idle_tc)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        ld_byte_d   = ld_byte_q;
        ld_vld_d    = 1'b0;
        swap_req_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_evt     = 1'b0;
        timer_act   = 1'b0;
`ifdef LOGO_FRAME_CHK_EN
        xor_d       = xor_q;
        tr_vld_d    = tr_vld_q;
        tr_byte_d   = tr_byte_q;
        // A trailer may land while the loader is still deciding to swap; hold it.
        if (state_q != ST_WAIT_SWAP && state_q != ST_CHECK) begin
            tr_vld_d = 1'b0;
        end else if (rx_vld && !tr_vld_q) begin
            tr_vld_d  = 1'b1;
            tr_byte_d = rx_byte;
        end
`endif

        case (state_q)
            ST_HUNT0: begin
                if (rx_vld && rx_byte == HDR0) begin
                    state_d = ST_HUNT1;
                end
            end
            ST_HUNT1: begin
                if (rx_vld) begin
                    if (rx_byte == HDR1) begin
                        state_d    = ST_PAYLOAD;
                        byte_cnt_d = '0;
`ifdef LOGO_FRAME_CHK_EN
                        xor_d      = 8'h00;
`endif
                    end else if (rx_byte != HDR0) begin
                        state_d = ST_HUNT0;
                    end
                end
            end
            ST_PAYLOAD: begin
                timer_act = 1'b1;
                if (rx_vld) begin
                    ld_vld_d   = 1'b1;
                    ld_byte_d  = rx_byte;
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef LOGO_FRAME_CHK_EN
                    xor_d      = xor_q ^ rx_byte;
`endif
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d    = ST_WAIT_SWAP;
                        wait_cnt_d = '0;
                    end
                end else if (idle_tc) begin
                    state_d = ST_RESYNC;
                    err_evt = 1'b1;
                end
            end
            ST_WAIT_SWAP: begin
                if (ld_swap_req) begin
`ifdef LOGO_FRAME_CHK_EN
                    state_d     = ST_CHECK;
`else
                    swap_req_d  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = ST_HUNT0;
`endif
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_RESYNC;
                    err_evt = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
`ifdef LOGO_FRAME_CHK_EN
            ST_CHECK: begin
                timer_act = 1'b1;
                if (tr_vld_q || rx_vld) begin
                    if ((tr_vld_q ? tr_byte_q : rx_byte) == xor_q) begin
                        swap_req_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = ST_HUNT0;
                    end else begin
                        state_d = ST_RESYNC;
                        err_evt = 1'b1;
                    end
                end else if (idle_tc) begin
                    state_d = ST_RESYNC;
                    err_evt = 1'b1;
                end
            end
`endif
            ST_RESYNC: begin
                state_d = ST_HUNT0;
            end
            default: begin
                state_d = ST_HUNT0;
            end
        endcase

        if (ld_swap_req && state_q != ST_WAIT_SWAP) begin
            err_evt = 1'b1;
        end
        err_cnt_d = (err_evt && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
        ld_rst_d  = (state_d == ST_RESYNC);
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state_q     <= ST_HUNT0;
            byte_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            ld_byte_q   <= 8'h00;
            ld_vld_q    <= 1'b0;
            ld_rst_q    <= 1'b1;
            swap_req_q  <= 1'b0;
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            ld_byte_q   <= ld_byte_d;
            ld_vld_q    <= ld_vld_d;
            ld_rst_q    <= ld_rst_d;
            swap_req_q  <= swap_req_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef LOGO_FRAME_CHK_EN
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            xor_q     <= 8'h00;
            tr_vld_q  <= 1'b0;
            tr_byte_q <= 8'h00;
        end else begin
            xor_q     <= xor_d;
            tr_vld_q  <= tr_vld_d;
            tr_byte_q <= tr_byte_d;
        end
    end
`endif

    assign ld_byte   = ld_byte_q;
    assign ld_vld    = ld_vld_q;
    assign ld_rst    = ld_rst_q;
    assign swap_req  = swap_req_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign state_o   = state_q;
    assign busy      = (state_q == ST_PAYLOAD) || (state_q == ST_WAIT_SWAP) ||
                       (state_q == ST_CHECK);

endmodule

// File: tb/tb_logo_frame_ctrl.sv
// tb/tb_logo_frame_ctrl.sv - randomized bench for logo_frame_ctrl against a stream-level reference
module tb_logo_frame_ctrl;

    localparam int         W       = 4;
    localparam int         H       = 4;
    localparam int         NB      = 2 * W * H;
    localparam int         TO      = 40;
    localparam int         EW      = 3;
    localparam int         ERR_MAX = (1 << EW) - 1;
    localparam logic [7:0] H0      = 8'hA5;
    localparam logic [7:0] H1      = 8'h5A;

    logic          clk_sys = 1'b0;
    logic          rst_sys_n = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_vld = 1'b0;
    logic [7:0]    ld_byte;
    logic          ld_vld;
    logic          ld_rst;
    logic          ld_swap_req = 1'b0;
    logic          swap_req;
    logic [15:0]   frame_cnt;
    logic [EW-1:0] err_cnt;
    logic [2:0]    state_o;
    logic          busy;

    logo_frame_ctrl #(
        .WIDTH(W), .HEIGHT(H), .HDR0(H0), .HDR1(H1), .TIMEOUT_CYC(TO), .ERR_W(EW)
    ) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .rx_byte(rx_byte), .rx_vld(rx_vld),
        .ld_byte(ld_byte), .ld_vld(ld_vld), .ld_rst(ld_rst), .ld_swap_req(ld_swap_req),
        .swap_req(swap_req), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
        .state_o(state_o), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: 0 hunting, 1 saw first header, 2 payload, 3 awaiting swap, 4 realign
    int         m_ph = 0;
    int         m_got = 0;
    int         m_idle = 0;
    int         m_wait = 0;
    int         exp_frame = 0;
    int         exp_err = 0;
    bit         exp_fwd;
    logic [7:0] exp_byte;
    bit         exp_swp;
    int         vld_seen = 0;
    int         swap_seen = 0;
    int         rst_seen = 0;

    task automatic model_step(input bit v, input logic [7:0] b, input bit s);
        bit err;
        err      = s && (m_ph != 3);
        exp_fwd  = 1'b0;
        exp_swp  = 1'b0;
        case (m_ph)
            0: if (v && b == H0) m_ph = 1;
            1: if (v) begin
                   if (b == H1) begin m_ph = 2; m_got = 0; m_idle = 0; end
                   else if (b != H0) m_ph = 0;
               end
            2: if (v) begin
                   exp_fwd = 1'b1; exp_byte = b; m_got++; m_idle = 0;
                   if (m_got == NB) begin m_ph = 3; m_wait = 0; end
               end else begin
                   m_idle++;
                   if (m_idle == TO) begin m_ph = 4; err = 1'b1; end
               end
            3: if (s) begin
                   exp_swp = 1'b1; exp_frame = (exp_frame + 1) % 65536; m_ph = 0;
               end else begin
                   m_wait++;
                   if (m_wait == 4) begin m_ph = 4; err = 1'b1; end
               end
            default: m_ph = 0;
        endcase
        if (err && exp_err < ERR_MAX) exp_err++;
    endtask

    task automatic cyc(input bit v, input logic [7:0] b, input bit s);
        rx_vld = v; rx_byte = b; ld_swap_req = s;
        model_step(v, b, s);
        @(posedge clk_sys); #1;
        check("ld_vld", ld_vld, exp_fwd);
        if (exp_fwd && ld_vld) check("ld_byte", ld_byte, exp_byte);
        check("swap_req", swap_req, exp_swp);
        check("ld_rst", ld_rst, m_ph == 4);
        check("state_o", state_o, m_ph);
        check("busy", busy, (m_ph == 2) || (m_ph == 3));
        check("frame_cnt", frame_cnt, exp_frame);
        check("err_cnt", err_cnt, exp_err);
        if (ld_vld) vld_seen++;
        if (swap_req) swap_seen++;
        if (ld_rst) rst_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic send_hdr();
        cyc(1'b1, H0, 1'b0);
        cyc(1'b1, H1, 1'b0);
    endtask

    task automatic send_payload(input int n, input int max_gap, input int long_gap_1_in);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (long_gap_1_in > 0 && $urandom_range(long_gap_1_in - 1, 0) == 0) g = TO + 1;
            idle(g);
            cyc(1'b1, 8'($urandom), 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        rst_sys_n = 1'b0; rx_vld = 1'b0; rx_byte = 8'h00; ld_swap_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys); #1;
            check("rst_ld_rst", ld_rst, 1);
            check("rst_state", state_o, 0);
            check("rst_frame", frame_cnt, 0);
            check("rst_err", err_cnt, 0);
            check("rst_ld_vld", ld_vld, 0);
            check("rst_swap", swap_req, 0);
        end
        rst_sys_n = 1'b1;
        m_ph = 0; exp_frame = 0; exp_err = 0;
    endtask

    initial begin
        do_reset(3);

        // Clean frame, loader swaps one cycle after the last byte
        vld_seen = 0; swap_seen = 0;
        send_hdr(); send_payload(NB, 3, 0); cyc(1'b0, 8'h00, 1'b1); idle(3);
        check("clean_vld_count", vld_seen, NB);
        check("clean_swaps", swap_seen, 1);
        check("clean_frames", frame_cnt, 1);
        check("clean_err", err_cnt, 0);

        // Lock on the second A5 after a leading 00
        vld_seen = 0;
        cyc(1'b1, 8'h00, 1'b0); cyc(1'b1, H0, 1'b0); cyc(1'b1, H0, 1'b0); cyc(1'b1, H1, 1'b0);
        send_payload(NB, 0, 0); cyc(1'b0, 8'h00, 1'b1); idle(2);
        check("hunt_vld_count", vld_seen, NB);
        check("hunt_frames", frame_cnt, 2);

        // Broken header forwards nothing
        vld_seen = 0;
        cyc(1'b1, H0, 1'b0); cyc(1'b1, 8'h00, 1'b0); cyc(1'b1, H1, 1'b0);
        cyc(1'b1, 8'h11, 1'b0); idle(3);
        check("badhdr_vld_count", vld_seen, 0);
        check("badhdr_state", state_o, 0);

        // Idle timeout mid-payload
        rst_seen = 0; swap_seen = 0;
        send_hdr(); send_payload(20, 2, 0); idle(TO + 3);
        check("timeout_rst_pulses", rst_seen, 1);
        check("timeout_err", err_cnt, 1);
        check("timeout_swaps", swap_seen, 0);

        // Spurious swap in HUNT0, then a missing swap in WAIT_SWAP
        cyc(1'b0, 8'h00, 1'b1); idle(1);
        check("spurious_err", err_cnt, 2);
        check("spurious_swaps", swap_seen, 0);
        send_hdr(); send_payload(NB, 1, 0); idle(6);
        check("noswap_err", err_cnt, 3);
        check("noswap_rst_pulses", rst_seen, 2);

        // Swap on the last allowed wait cycle is still accepted
        send_hdr(); send_payload(NB, 0, 0); idle(3); cyc(1'b0, 8'h00, 1'b1); idle(2);
        check("late_swap_frames", frame_cnt, 3);

        // Reset mid-payload abandons the frame
        send_hdr(); send_payload(20, 1, 0);
        do_reset(2);
        swap_seen = 0;
        send_hdr(); send_payload(NB, 2, 0); cyc(1'b0, 8'h00, 1'b1); idle(2);
        check("after_rst_frames", frame_cnt, 1);
        check("after_rst_swaps", swap_seen, 1);

        // Timeout and spurious swap in the same cycle count once
        send_hdr(); send_payload(5, 0, 0); idle(TO - 1); cyc(1'b0, 8'h00, 1'b1); idle(2);
        check("coincident_err", err_cnt, 1);

        // Saturation
        for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b1);
        idle(1);
        check("err_saturated", err_cnt, ERR_MAX);

        // Random soak
        do_reset(1);
        for (int f = 0; f < 10; f++) begin
            for (int j = 0; j < int'($urandom_range(4, 0)); j++) begin
                logic [7:0] junk;
                junk = ($urandom_range(2, 0) == 0) ? H0 : 8'($urandom);
                cyc(1'b1, junk, $urandom_range(60, 0) == 0);
            end
            send_hdr();
            send_payload(NB, 3, 80);
            idle($urandom_range(5, 0));
            cyc(1'b0, 8'($urandom), 1'b1);
            idle(3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
